// File: rtl/chip8_callret_ctrl_pkg.sv
// Shared types for the Chip-8 CALL/RET initiator and the return-address stack.
//   stack_op_t      : command from this block to the stack block
//   callret_state_t : sequencer states of chip8_callret_ctrl
//   cnt_width()     : width of the PUSH/POP hold-cycle counter
package chip8_callret_ctrl_pkg;

  typedef enum logic [1:0] {
    STACK_HOLD = 2'd0,
    STACK_PUSH = 2'd1,
    STACK_POP  = 2'd2
  } stack_op_t;

  typedef enum logic [2:0] {
    CR_IDLE,
    CR_PUSH,
    CR_POP,
    CR_RELEASE,
    CR_DONE
  } callret_state_t;

  localparam int unsigned DEPTH_W = 5;

  // Counter must hold max(push_cycles, pop_cycles) - 1; sized with one spare code.
  function automatic int unsigned cnt_width(int unsigned push_cycles, int unsigned pop_cycles);
    int unsigned m;
    m = (push_cycles > pop_cycles) ? push_cycles : pop_cycles;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/chip8_callret_ctrl_if.sv
// Decoder/stack-facing signal bundle of chip8_callret_ctrl.
//   master : environment side (decoder drives requests/pc/target, stack drives stack_rdata)
//   slave  : chip8_callret_ctrl side
// Signals: call_req, ret_req, pc[15:0], target[11:0], stack_op, stack_wdata[15:0],
//          stack_rdata[15:0], busy, done, next_pc[15:0], fault, depth[4:0]
interface chip8_callret_ctrl_if;
  import chip8_callret_ctrl_pkg::*;

  logic                call_req;
  logic                ret_req;
  logic [15:0]         pc;
  logic [11:0]         target;
  stack_op_t           stack_op;
  logic [15:0]         stack_wdata;
  logic [15:0]         stack_rdata;
  logic                busy;
  logic                done;
  logic [15:0]         next_pc;
  logic                fault;
  logic [DEPTH_W-1:0]  depth;

  modport master (
    output call_req, ret_req, pc, target, stack_rdata,
    input  stack_op, stack_wdata, busy, done, next_pc, fault, depth
  );

  modport slave (
    input  call_req, ret_req, pc, target, stack_rdata,
    output stack_op, stack_wdata, busy, done, next_pc, fault, depth
  );
endinterface

// File: rtl/chip8_callret_ctrl.sv
// CPU-side initiator for the Chip-8 return-address stack.
// Turns CALL (2NNN) / RET (00EE) requests into a held STACK_PUSH / STACK_POP sequence,
// followed by one STACK_HOLD cycle that re-arms the stack, then a one-cycle done pulse
// carrying next_pc. Tracks stack depth and reports overflow/underflow (or a conflicting
// CALL+RET request) as fault without issuing any stack operation.
// Ports:
//   cpu_clk : clock
//   reset   : asynchronous, active-high reset
//   bus     : chip8_callret_ctrl_if.slave (requests, stack handshake, results)
module chip8_callret_ctrl
  import chip8_callret_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned PUSH_CYCLES = 2,
  parameter int unsigned POP_CYCLES  = 2,
  parameter int unsigned RET_OFFSET  = 2
) (
  input  logic                 cpu_clk,
  input  logic                 reset,
  chip8_callret_ctrl_if.slave  bus
);

  localparam int unsigned          CNT_W     = cnt_width(PUSH_CYCLES, POP_CYCLES);
  localparam logic [CNT_W-1:0]     PUSH_LAST = CNT_W'(PUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0]     POP_LAST  = CNT_W'(POP_CYCLES - 1);
  localparam logic [DEPTH_W-1:0]   DEPTH_MAX = DEPTH_W'(DEPTH);

  callret_state_t      state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [15:0]         wdata_q, wdata_d;
  logic [15:0]         next_pc_q, next_pc_d;
  logic                fault_q, fault_d;
  logic [DEPTH_W-1:0]  depth_q, depth_d;
  logic                pop_q, pop_d;     // RELEASE was reached from POP
  stack_op_t           stack_op;

  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      state_q   <= CR_IDLE;
      cnt_q     <= '0;
      wdata_q   <= '0;
      next_pc_q <= '0;
      fault_q   <= 1'b0;
      depth_q   <= '0;
      pop_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wdata_q   <= wdata_d;
      next_pc_q <= next_pc_d;
      fault_q   <= fault_d;
      depth_q   <= depth_d;
      pop_q     <= pop_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wdata_d   = wdata_q;
    next_pc_d = next_pc_q;
    fault_d   = fault_q;
    depth_d   = depth_q;
    pop_d     = pop_q;
    stack_op  = STACK_HOLD;

    unique case (state_q)
      CR_IDLE: begin
        if (bus.call_req || bus.ret_req) begin
          fault_d = 1'b0;
          // Conflicting request, overflow and underflow all share one path:
          // straight to DONE, pc echoed back, stack untouched.
          if ((bus.call_req && bus.ret_req) ||
              (bus.call_req && depth_q == DEPTH_MAX) ||
              (bus.ret_req && depth_q == '0)) begin
            fault_d   = 1'b1;
            next_pc_d = bus.pc;
            state_d   = CR_DONE;
          end else if (bus.call_req) begin
            wdata_d   = bus.pc + 16'(RET_OFFSET);
            next_pc_d = {4'h0, bus.target};
            pop_d     = 1'b0;
            state_d   = CR_PUSH;
          end else begin
            pop_d     = 1'b1;
            state_d   = CR_POP;
          end
        end
      end
      CR_PUSH: begin
        stack_op = STACK_PUSH;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == PUSH_LAST) state_d = CR_RELEASE;
      end
      CR_POP: begin
        stack_op = STACK_POP;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == POP_LAST) state_d = CR_RELEASE;
      end
      CR_RELEASE: begin
        if (pop_q) begin
          next_pc_d = bus.stack_rdata;
          depth_d   = depth_q - 1'b1;
        end else begin
          depth_d   = depth_q + 1'b1;
        end
        state_d = CR_DONE;
      end
      CR_DONE: begin
        state_d = CR_IDLE;
      end
      default: begin
        state_d = CR_IDLE;
      end
    endcase

    if (state_d != state_q) cnt_d = '0;
  end

  assign bus.stack_op    = stack_op;
  assign bus.stack_wdata = wdata_q;
  assign bus.busy        = (state_q != CR_IDLE);
  assign bus.done        = (state_q == CR_DONE);
  assign bus.next_pc     = next_pc_q;
  assign bus.fault       = fault_q;
  assign bus.depth       = depth_q;

endmodule
